carregador_programa: RTL and testbench

Program loader for the multicycle RISC-V datapath. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word into the instruction memory that the fetch stage reads, then signals completion so the datapath state machine can leave reset and begin fetching from PC 0. It is the writer side of the instruction-memory read path.

---
 rtl/carregador_programa.sv | 90 +++++++++
 tb/tb_carregador_programa.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
// carregador_programa: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory
module carregador_programa #(
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_WORDS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  loading,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);
    typedef enum logic [2:0] {OCIOSO, RECEBE, ESCREVE, CONCLUIDO, ERRO} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(MAX_WORDS);

    state_t                r_state, w_next;
    logic [ADDR_WIDTH:0]   r_len, r_count;
    logic [1:0]            r_idx;
    logic [23:0]           r_word;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  w_accept, w_len_ok, w_xfer;
    logic [ADDR_WIDTH:0]   w_count_inc;

    assign w_accept    = start && r_state != RECEBE && r_state != ESCREVE;
    assign w_len_ok    = num_words != '0 && num_words <= MAX_LEN;
    assign w_xfer      = byte_valid && r_state == RECEBE;
    assign w_count_inc = r_count + 1'b1;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign word_count  = r_count;

    // next state and state-decoded outputs; idle states (and any unused code) all honour start
    always_comb begin
        w_next     = r_state;
        byte_ready = r_state == RECEBE;
        imem_we    = r_state == ESCREVE;
        loading    = r_state == RECEBE || r_state == ESCREVE;
        done       = r_state == CONCLUIDO;
        error      = r_state == ERRO;
        case (r_state)
            RECEBE:  w_next = (byte_valid && r_idx == 2'd3) ? ESCREVE : RECEBE;
            ESCREVE: w_next = (w_count_inc == r_len) ? CONCLUIDO : RECEBE;
            default: w_next = w_accept ? (w_len_ok ? RECEBE : ERRO) : r_state;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= OCIOSO;
        else     r_state <= w_next;
    end

    // byte shift-in, write-port capture on byte 3, and word counting after each write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept && w_len_ok) begin
                r_len   <= num_words;
                r_count <= '0;
                r_idx   <= '0;
                r_word  <= '0;
            end
            if (w_xfer) begin
                r_idx  <= r_idx + 1'b1;
                r_word <= {byte_in, r_word[23:8]};
                if (r_idx == 2'd3) begin
                    r_addr  <= r_count[ADDR_WIDTH-1:0];
                    r_wdata <= {byte_in, r_word};
                end
            end
            if (r_state == ESCREVE) r_count <= w_count_inc;
        end
    end
endmodule

// File: tb/tb_carregador_programa.sv
// tb_carregador_programa: randomized self-checking bench for the program loader against a byte-stream reference model
module tb_carregador_programa;
    localparam int AW = 5;
    localparam int MW = 32;

    logic          clk = 0, rst = 0, start = 0, byte_valid = 0;
    logic [AW:0]   num_words = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_ready, imem_we, loading, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;

    int n_checks = 0, n_fail = 0, cyc = 0;
    logic [7:0]  tx_q[$];
    int          wa_q[$], wc_q[$];
    logic [31:0] wd_q[$];

    carregador_programa #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .loading(loading), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // log every memory write seen on the port
    always @(negedge clk) if (imem_we === 1'b1) begin
        wa_q.push_back(int'(imem_addr));
        wd_q.push_back(imem_wdata);
        wc_q.push_back(cyc);
    end

    // reference: word w is bytes 4w..4w+3 in little-endian order
    function automatic logic [31:0] model_word(int w);
        return 32'(tx_q[4*w]) | (32'(tx_q[4*w+1]) << 8) | (32'(tx_q[4*w+2]) << 16) | (32'(tx_q[4*w+3]) << 24);
    endfunction

    task automatic clear_log;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
    endtask

    task automatic fill(int n);
        tx_q.delete();
        repeat (4 * n) tx_q.push_back(8'($urandom));
    endtask

    task automatic do_start(int n);
        @(negedge clk); start = 1; num_words = (AW + 1)'(n);
        @(negedge clk); start = 0;
    endtask

    // mode 0: always valid, 1: 1,0,1,1,0,1 pattern held high while not ready, 2: random
    task automatic send_range(int mode, int lo, int hi);
        int i = lo, g = 0, k = 0;
        logic v;
        while (i < hi && g < 4000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (!byte_ready || (k % 6 != 1 && k % 6 != 4)) : 1'($urandom_range(0, 1));
            byte_valid = v;
            byte_in = v ? tx_q[i] : 8'($urandom);
            if (v && byte_ready) i++;
            k++; g++;
            @(negedge clk);
        end
        byte_valid = 0;
        if (i < hi) begin n_checks++; n_fail++; $display("FAIL send_timeout: sent %0d required %0d", i, hi); end
    endtask

    task automatic wait_end(int limit);
        int g = 0;
        while (done !== 1'b1 && error !== 1'b1 && g < limit) begin @(negedge clk); g++; end
        if (g >= limit) begin n_checks++; n_fail++; $display("FAIL wait_timeout: no done/error within %0d cycles", limit); end
    endtask

    task automatic test_reset;
        @(negedge clk); #2 rst = 1; #1;
        n_checks++; if ({byte_ready, imem_we, loading, done, error} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got %b required 00000", {byte_ready, imem_we, loading, done, error}); end
        n_checks++; if (imem_addr !== '0 || imem_wdata !== '0) begin n_fail++; $display("FAIL rst_port: got %h/%h required 0/0", imem_addr, imem_wdata); end
        n_checks++; if (word_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", word_count); end
        @(negedge clk); rst = 0; byte_valid = 1;
        repeat (3) @(negedge clk);
        n_checks++; if (byte_ready !== 1'b0 || loading !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b%b required 00", byte_ready, loading); end
        byte_valid = 0;
    endtask

    task automatic test_two_word;
        int t0;
        tx_q = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h30, 8'h00};
        clear_log();
        do_start(2); t0 = cyc;
        n_checks++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready: got %b required 1", byte_ready); end
        send_range(0, 0, 8);
        wait_end(50);
        n_checks++; if (cyc - t0 !== 10) begin n_fail++; $display("FAIL load_cycles: got %0d required 10", cyc - t0); end
        n_checks++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL two_nwrites: got %0d required 2", wa_q.size()); end
        if (wa_q.size() == 2) begin
            n_checks++; if (wa_q[0] !== 0 || wd_q[0] !== 32'h00500513) begin n_fail++; $display("FAIL two_w0: got %0d/%h required 0/00500513", wa_q[0], wd_q[0]); end
            n_checks++; if (wa_q[1] !== 1 || wd_q[1] !== 32'h00300593) begin n_fail++; $display("FAIL two_w1: got %0d/%h required 1/00300593", wa_q[1], wd_q[1]); end
            n_checks++; if (wc_q[1] - wc_q[0] !== 5) begin n_fail++; $display("FAIL two_spacing: got %0d required 5", wc_q[1] - wc_q[0]); end
        end
        n_checks++; if (done !== 1'b1 || word_count !== 2) begin n_fail++; $display("FAIL two_done: got %b/%0d required 1/2", done, word_count); end
    endtask

    task automatic test_backpressure;
        fill(3); clear_log();
        do_start(3);
        send_range(1, 0, 12);
        wait_end(100);
        n_checks++; if (wa_q.size() !== 3) begin n_fail++; $display("FAIL bp_nwrites: got %0d required 3", wa_q.size()); end
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            n_checks++; if (wa_q[i] !== i || wd_q[i] !== model_word(i)) begin n_fail++; $display("FAIL bp_word%0d: got %0d/%h required %0d/%h", i, wa_q[i], wd_q[i], i, model_word(i)); end
        end
        n_checks++; if (done !== 1'b1 || word_count !== 3) begin n_fail++; $display("FAIL bp_done: got %b/%0d required 1/3", done, word_count); end
    endtask

    task automatic test_length_errors;
        clear_log();
        do_start(0);
        n_checks++; if (error !== 1'b1 || byte_ready !== 1'b0) begin n_fail++; $display("FAIL len0: got err=%b rdy=%b required 1/0", error, byte_ready); end
        byte_valid = 1; repeat (6) @(negedge clk); byte_valid = 0;
        n_checks++; if (wa_q.size() !== 0 || error !== 1'b1) begin n_fail++; $display("FAIL len0_hold: got %0d writes err=%b required 0/1", wa_q.size(), error); end
        do_start(MW + 1);
        n_checks++; if (error !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL len33: got err=%b done=%b required 1/0", error, done); end
        fill(1);
        do_start(1);
        n_checks++; if (error !== 1'b0 || loading !== 1'b1 || byte_ready !== 1'b1 || word_count !== 0) begin n_fail++; $display("FAIL err_recover: got err=%b ld=%b rdy=%b wc=%0d required 0/1/1/0", error, loading, byte_ready, word_count); end
        send_range(2, 0, 4);
        wait_end(100);
        n_checks++; if (wa_q.size() !== 1 || (wa_q.size() == 1 && (wa_q[0] !== 0 || wd_q[0] !== model_word(0)))) begin n_fail++; $display("FAIL err_load: got %0d writes required 1 at 0 = %h", wa_q.size(), model_word(0)); end
    endtask

    task automatic test_reset_mid_word;
        fill(2);
        do_start(2);
        send_range(0, 0, 6);
        #2 rst = 1; #1;
        n_checks++; if (loading !== 1'b0 || byte_ready !== 1'b0 || word_count !== 0 || imem_wdata !== 0) begin n_fail++; $display("FAIL async_rst: got ld=%b rdy=%b wc=%0d wd=%h required 0/0/0/0", loading, byte_ready, word_count, imem_wdata); end
        @(negedge clk); rst = 0; byte_valid = 1;
        repeat (3) @(negedge clk);
        n_checks++; if (byte_ready !== 1'b0 || word_count !== 0) begin n_fail++; $display("FAIL post_rst_idle: got rdy=%b wc=%0d required 0/0", byte_ready, word_count); end
        byte_valid = 0;
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_log();
        do_start(1);
        send_range(0, 0, 4);
        wait_end(50);
        n_checks++; if (wa_q.size() !== 1 || (wa_q.size() == 1 && (wa_q[0] !== 0 || wd_q[0] !== 32'hDDCCBBAA))) begin n_fail++; $display("FAIL rst_reload: got %0d writes required one at 0 = ddccbbaa", wa_q.size()); end
        n_checks++; if (done !== 1'b1 || word_count !== 1) begin n_fail++; $display("FAIL rst_reload_done: got %b/%0d required 1/1", done, word_count); end
    endtask

    task automatic test_restart;
        fill(2); clear_log();
        do_start(2);
        send_range(2, 0, 2);
        @(negedge clk); start = 1; num_words = 1;
        @(negedge clk); start = 0;
        n_checks++; if (loading !== 1'b1 || word_count !== 0) begin n_fail++; $display("FAIL start_ignored: got ld=%b wc=%0d required 1/0", loading, word_count); end
        send_range(2, 2, 8);
        wait_end(200);
        n_checks++; if (wa_q.size() !== 2 || word_count !== 2) begin n_fail++; $display("FAIL ignored_len: got %0d writes wc=%0d required 2/2", wa_q.size(), word_count); end
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            n_checks++; if (wa_q[i] !== i || wd_q[i] !== model_word(i)) begin n_fail++; $display("FAIL ignored_word%0d: got %0d/%h required %0d/%h", i, wa_q[i], wd_q[i], i, model_word(i)); end
        end
        fill(1); clear_log();
        do_start(1);
        n_checks++; if (done !== 1'b0 || word_count !== 0 || byte_ready !== 1'b1) begin n_fail++; $display("FAIL restart: got done=%b wc=%0d rdy=%b required 0/0/1", done, word_count, byte_ready); end
        send_range(0, 0, 4);
        wait_end(50);
        n_checks++; if (wa_q.size() !== 1 || (wa_q.size() == 1 && (wa_q[0] !== 0 || wd_q[0] !== model_word(0)))) begin n_fail++; $display("FAIL restart_load: got %0d writes required one at 0 = %h", wa_q.size(), model_word(0)); end
    endtask

    task automatic test_random;
        int n;
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? MW : $urandom_range(1, 8);
            fill(n); clear_log();
            do_start(n);
            send_range(r == 0 ? 0 : 2, 0, 4 * n);
            wait_end(2000);
            n_checks++; if (wa_q.size() !== n || done !== 1'b1 || word_count !== (AW + 1)'(n)) begin n_fail++; $display("FAIL rnd%0d_len: got %0d writes done=%b wc=%0d required %0d", r, wa_q.size(), done, word_count, n); end
            for (int i = 0; i < n && i < wa_q.size(); i++) begin
                n_checks++; if (wa_q[i] !== i || wd_q[i] !== model_word(i)) begin n_fail++; $display("FAIL rnd%0d_word%0d: got %0d/%h required %0d/%h", r, i, wa_q[i], wd_q[i], i, model_word(i)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_backpressure();
        test_length_errors();
        test_reset_mid_word();
        test_restart();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
